// File: rtl/mult8_seq_shiftadd_if.sv
// Operand/product handshake bundle for the sequential shift-add multiplier.
// Ports: in_valid/in_ready/in_a/in_b carry operands toward the multiplier;
//        out_valid/out_ready/out_prod carry the product back to the consumer.
// master = operand source and product sink; slave = the multiplier itself.
interface mult8_seq_shiftadd_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_prod;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_prod
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_prod
  );
endinterface

// File: rtl/mult8_seq_shiftadd.sv
// Purpose: iterative unsigned WIDTHxWIDTH shift-add multiplier, one partial-product column per cycle,
//          with optional truncation of the TRUNC least-significant columns of every partial product.
// Latency: accept edge E0 -> out_valid high after edge E0+WIDTH; one product per WIDTH+2 cycles at best.
// Backpressure: out_valid/out_prod held in DONE until out_ready; in_ready is high only in IDLE.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset (sampled on clk)
//   io     mult8_seq_shiftadd_if.slave: operand handshake (in_*) and product handshake (out_*)
//   busy   high while a product is being formed or waiting to be taken (RUN or DONE)
module mult8_seq_shiftadd #(
  parameter int WIDTH = 8,
  // Number of low product columns zeroed in every partial product; 0..2*WIDTH-1, 0 = exact.
  parameter int TRUNC = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mult8_seq_shiftadd_if.slave   io,
  output logic                  busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Columns that survive truncation; all ones when TRUNC = 0.
  localparam logic [PW-1:0] KEEP_MASK = ~((PW'(1) << TRUNC) - PW'(1));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [PW-1:0]    acc_q;
  logic [PW-1:0]    prod_q;
  logic [CW-1:0]    cnt_q;

  // Control strobes decoded from the state.
  logic start;
  logic step;
  logic last;

  logic [PW-1:0] pp;
  logic [PW-1:0] acc_sum;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and handshake outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    io.in_ready  = 1'b0;
    io.out_valid = 1'b0;
    busy         = 1'b0;
    start        = 1'b0;
    step         = 1'b0;
    last         = 1'b0;

    case (state_q)
      IDLE: begin
        io.in_ready = 1'b1;
        if (io.in_valid) begin
          start   = 1'b1;
          state_d = RUN;
        end
      end

      RUN: begin
        busy = 1'b1;
        step = 1'b1;
        // Always walk every multiplier bit, even when b is zero, so the
        // latency seen downstream never depends on operand values.
        if (cnt_q == CW'(WIDTH - 1)) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end

      DONE: begin
        busy         = 1'b1;
        io.out_valid = 1'b1;
        if (io.out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: partial product for the current column and running sum
  // ---------------------------------------------------------------------------
  always_comb begin
    pp      = ({{WIDTH{1'b0}}, a_q} << cnt_q) & KEEP_MASK;
    // 2*WIDTH bits always hold the full product, so no carry-out is kept.
    acc_sum = b_q[cnt_q] ? (acc_q + pp) : acc_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      prod_q <= '0;
    end else begin
      if (start) begin
        // Operands are captured once; the source may change them afterwards.
        a_q   <= io.in_a;
        b_q   <= io.in_b;
        acc_q <= '0;
        cnt_q <= '0;
      end
      if (step) begin
        acc_q <= acc_sum;
        if (last) begin
          cnt_q  <= '0;
          // Separate result register: out_prod only changes when a complete
          // product is ready and otherwise keeps the last delivered value.
          prod_q <= acc_sum;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

  assign io.out_prod = prod_q;

  // The offered product must not move while the consumer stalls.
  a_hold_in_done : assert property (
    @(posedge clk) disable iff (!rst_n)
    (state_q == DONE && !io.out_ready) |=> (state_q == DONE && $stable(prod_q))
  );

endmodule

// File: tb/tb_mult8_seq_shiftadd.sv
// Bench for mult8_seq_shiftadd: three instances (TRUNC = 0, 3, 4) driven in lockstep.
// Directed vectors carry hand-computed products; a scoreboard queue holds expectations
// and a negedge monitor pops and compares on every output handshake.
module tb_mult8_seq_shiftadd;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mult8_seq_shiftadd_if #(.WIDTH(8)) if0 ();
  mult8_seq_shiftadd_if #(.WIDTH(8)) if3 ();
  mult8_seq_shiftadd_if #(.WIDTH(8)) if4 ();
  logic busy0, busy3, busy4;

  mult8_seq_shiftadd #(.WIDTH(8), .TRUNC(0)) dut0 (.clk(clk), .rst_n(rst_n), .io(if0), .busy(busy0));
  mult8_seq_shiftadd #(.WIDTH(8), .TRUNC(3)) dut3 (.clk(clk), .rst_n(rst_n), .io(if3), .busy(busy3));
  mult8_seq_shiftadd #(.WIDTH(8), .TRUNC(4)) dut4 (.clk(clk), .rst_n(rst_n), .io(if4), .busy(busy4));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] e0;
    logic [15:0] e3;
    logic [15:0] e4;
    string       tag;
  } exp_t;

  exp_t sbq[$];

  typedef struct packed {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] e0;
    logic [15:0] e3;
    logic [15:0] e4;
    logic [3:0]  stall;
    logic        pulse;
  } vec_t;

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    end
  endtask

  // Reference: sum of b[i] * ((a << i) with the low t columns cleared).
  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input int t);
    logic [15:0] s;
    logic [15:0] m;
    s = 16'h0000;
    m = 16'hFFFF << t;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) s = s + (({8'h00, a} << i) & m);
    end
    return s;
  endfunction

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic ordy);
    if0.in_valid = v; if0.in_a = a; if0.in_b = b; if0.out_ready = ordy;
    if3.in_valid = v; if3.in_a = a; if3.in_b = b; if3.out_ready = ordy;
    if4.in_valid = v; if4.in_a = a; if4.in_b = b; if4.out_ready = ordy;
  endtask

  // Monitor: a handshake completes on the next rising edge when valid & ready are seen here.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && if0.out_valid === 1'b1 && if0.out_ready === 1'b1) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_product: got 0x%04h with no pending expectation", if0.out_prod);
      end else begin
        e = sbq.pop_front();
        check16({e.tag, "/prod_t0"}, if0.out_prod, e.e0);
        check16({e.tag, "/valid_t3"}, {15'd0, if3.out_valid}, 16'd1);
        check16({e.tag, "/prod_t3"}, if3.out_prod, e.e3);
        check16({e.tag, "/valid_t4"}, {15'd0, if4.out_valid}, 16'd1);
        check16({e.tag, "/prod_t4"}, if4.out_prod, e.e4);
      end
    end
  end

  // One full transaction, called #1 after a rising edge with the DUTs in IDLE.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] e0, input logic [15:0] e3, input logic [15:0] e4,
                       input int stall, input bit pulse, input string tag);
    exp_t e;
    int   lat;
    check16({tag, "/in_ready_idle"}, {15'd0, if0.in_ready}, 16'd1);
    drive(1'b1, a, b, 1'b0);
    e.e0 = e0; e.e3 = e3; e.e4 = e4; e.tag = tag;
    sbq.push_back(e);
    @(posedge clk); #1;                 // E0
    drive(1'b0, ~a, ~b, 1'b0);          // operands must already be held inside
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (pulse && lat == 3) begin
        check16({tag, "/in_ready_run"}, {15'd0, if0.in_ready}, 16'd0);
        drive(1'b1, 8'h11, 8'h22, 1'b0);
      end
    end while (if0.out_valid !== 1'b1 && lat < 40);
    check16({tag, "/latency"}, 16'(lat), 16'd8);
    for (int s = 0; s < stall; s++) begin
      check16({tag, "/hold_valid"}, {15'd0, if0.out_valid}, 16'd1);
      check16({tag, "/hold_prod"}, if0.out_prod, e0);
      if (pulse) check16({tag, "/in_ready_done"}, {15'd0, if0.in_ready}, 16'd0);
      @(posedge clk); #1;
    end
    drive(1'b0, 8'h00, 8'h00, 1'b1);
    @(posedge clk); #1;                 // output handshake edge
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    check16({tag, "/in_ready_after"}, {15'd0, if0.in_ready}, 16'd1);
    check16({tag, "/valid_dropped"}, {15'd0, if0.out_valid}, 16'd0);
    check16({tag, "/busy_after"}, {15'd0, busy0}, 16'd0);
    check16({tag, "/prod_kept"}, if0.out_prod, e0);
  endtask

  vec_t dir[4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks so far", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ra, rb;
    // a, b, exact, TRUNC=3, TRUNC=4, stall cycles, pulse in_valid during RUN/DONE
    dir[0] = '{8'hFF, 8'hFF, 16'hFE01, 16'hFDF0, 16'hFDD0, 4'd0, 1'b0};
    dir[1] = '{8'h00, 8'hFF, 16'h0000, 16'h0000, 16'h0000, 4'd1, 1'b0};
    dir[2] = '{8'h5A, 8'h01, 16'h005A, 16'h0058, 16'h0050, 4'd0, 1'b0};
    dir[3] = '{8'h0F, 8'h0F, 16'h00E1, 16'h00D0, 16'h00B0, 4'd5, 1'b1};

    drive(1'b0, 8'h00, 8'h00, 1'b0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check16("rst/in_ready", {15'd0, if0.in_ready}, 16'd1);
    check16("rst/out_valid", {15'd0, if0.out_valid}, 16'd0);
    check16("rst/busy", {15'd0, busy0}, 16'd0);
    check16("rst/out_prod", if0.out_prod, 16'h0000);
    rst_n = 1'b1;

    // out_ready outside DONE is ignored.
    drive(1'b0, 8'h00, 8'h00, 1'b1);
    repeat (3) begin
      @(posedge clk); #1;
      check16("idle_ordy/out_valid", {15'd0, if0.out_valid}, 16'd0);
      check16("idle_ordy/in_ready", {15'd0, if0.in_ready}, 16'd1);
    end
    drive(1'b0, 8'h00, 8'h00, 1'b0);

    for (int i = 0; i < 4; i++) begin
      do_op(dir[i].a, dir[i].b, dir[i].e0, dir[i].e3, dir[i].e4,
            int'(dir[i].stall), dir[i].pulse, $sformatf("dir%0d", i));
    end

    // Reset during RUN: no product may come out of the aborted operation.
    drive(1'b1, 8'h77, 8'h99, 1'b0);
    @(posedge clk); #1;                 // E0
    drive(1'b0, 8'h00, 8'h00, 1'b1);    // consumer ready the whole time
    repeat (3) @(posedge clk);          // E1..E3
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;                 // 4th RUN edge, reset wins
    rst_n = 1'b1;
    check16("midrst/in_ready", {15'd0, if0.in_ready}, 16'd1);
    check16("midrst/out_valid", {15'd0, if0.out_valid}, 16'd0);
    check16("midrst/busy", {15'd0, busy0}, 16'd0);
    check16("midrst/out_prod", if0.out_prod, 16'h0000);
    @(posedge clk); #1;
    check16("midrst/still_idle", {15'd0, if0.out_valid}, 16'd0);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    do_op(8'h03, 8'h05, 16'h000F, 16'h0008, 16'h0000, 0, 1'b0, "post_rst");

    // Random operand pairs with random consumer stalls, reference model expectations.
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      do_op(ra, rb, model(ra, rb, 0), model(ra, rb, 3), model(ra, rb, 4),
            int'($urandom_range(0, 3)), 1'b0, $sformatf("rnd%0d", i));
    end

    @(posedge clk); #1;
    check16("queue_drained", 16'(sbq.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mult8_seq_shiftadd.md
Name: mult8_seq_shiftadd

Overview:
- Iterative, multi-cycle 8x8 unsigned multiplier with valid/ready handshakes on both sides.
- Sits directly upstream of the combinational approximate-multiplier partitions. It is the sequential exact/approximate product source, and its output is compared against, or replaces, the partition-synthesised datapath.
- Processes one product column-add per cycle.
- Optional LSB column truncation models the approximation error the partition stages introduce.

Parameters:
- WIDTH, 8: operand width in bits. The product is 2*WIDTH bits.
- TRUNC, 0: number of least-significant product columns forced to zero in every partial product before accumulation. 0 gives an exact product. Legal range is 0..2*WIDTH-1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- in_a  in  WIDTH  multiplicand, unsigned.
- in_b  in  WIDTH  multiplier, unsigned.
- out_valid  out  1  out_prod valid.
- out_ready  in  1  consumer accepts product.
- out_prod  out  2*WIDTH  product, unsigned.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low, sampled only on the rising edge of clk.
- Reset values:
  - state = IDLE.
  - in_ready = 1, out_valid = 0, busy = 0.
  - out_prod = 0, accumulator = 0, counter = 0.
  - Operand registers = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid & in_ready: latch in_a and in_b, clear accumulator to 0, set counter to 0, go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - in_ready = 0.
  - Each edge: if b_reg[counter] = 1, add pp to the accumulator. pp = (a_reg << counter) with bits [TRUNC-1:0] cleared.
  - The add is 2*WIDTH wide. No overflow is possible, so there is no carry-out.
  - counter increments each edge.
  - The edge where counter = WIDTH-1 performs the last add and moves to DONE.
  - RUN always lasts exactly WIDTH cycles. There is no early termination, including when b = 0.
- DONE:
  - out_valid = 1 and out_prod = accumulator.
  - Both are held stable while out_ready = 0.
  - On an edge with out_ready = 1: go to IDLE and drop out_valid.
  - out_prod keeps its last value after the handshake; only out_valid qualifies it.
- Latency: the accept edge is E0. out_valid goes high after edge E0+WIDTH (8 cycles for the default) and stays high until the output handshake.
- Throughput: one product per WIDTH+2 cycles minimum. in_ready returns to 1 the cycle after the output handshake.
- in_ready is a pure function of state (IDLE only). in_valid in RUN or DONE is ignored and the operands are not captured.
- out_ready asserted while not in DONE has no effect.
- Reset mid-operation: rst_n low at any edge, in any state, forces reset values on that edge. A partial product is never emitted.
- Simultaneous reset and handshake: reset wins.
- TRUNC = 0: out_prod equals in_a*in_b exactly.
- TRUNC > 0: out_prod equals the sum over i of b[i]*((a<<i) & ~((1<<TRUNC)-1)). The result is always ≤ the exact product.
- Operand registers are not modified during RUN. The upstream source may change in_a/in_b freely after the accept edge.

Test Plan:
- Exact max: TRUNC=0, accept a=0xFF, b=0xFF at E0 -> out_valid rises after E8, out_prod=0xFE01.
- Zero and identity: a=0x00, b=0xFF -> 0x0000 after 8 RUN cycles (no early exit). Then a=0x5A, b=0x01 -> 0x005A.
- Truncation: TRUNC=4, a=0x0F, b=0x0F -> out_prod=0x00B0 (exact value 0x00E1).
- Backpressure: out_ready held low 5 cycles in DONE -> out_valid=1 and out_prod stable all 5 cycles. in_valid pulses during RUN/DONE are ignored (in_ready=0). After the handshake, in_ready=1 on the next cycle.
- Reset mid-RUN: rst_n low at the 4th RUN edge -> next cycle state IDLE, out_valid=0, out_prod=0, in_ready=1. A following a=0x03, b=0x05 -> 0x000F.
- Back-to-back random: 1000 random operand pairs, TRUNC=0 and TRUNC=3, with random out_ready stalls -> every out_prod matches the reference model formula, and no products are dropped or duplicated.
